datapath_core: RTL and testbench

//  Minimal execute datapath: 4-entry register file feeding a combinational ALU; the ALU result
//  is written back to the register file. Sits under the control unit, which drives

---
 rtl/datapath_core_if.sv | 36 +++
 rtl/datapath_core.sv | 110 +++++++++++
 tb/tb_datapath_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/datapath_core_if.sv
// Bus between the control unit and datapath_core: operand/write addresses, ALU op, observation outputs.
// Optional flag outputs (carry, overflow, negative) exist only when DATAPATH_FLAGS_EN is defined.
interface datapath_core_if #(
  parameter int WIDTH = 32
);
  logic             wr;
  logic [1:0]       addr1;
  logic [1:0]       addr2;
  logic [1:0]       addr3;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
`ifdef DATAPATH_FLAGS_EN
  logic             carry;
  logic             overflow;
  logic             negative;
`endif

  modport master (
    output wr, addr1, addr2, addr3, ALUControl,
`ifdef DATAPATH_FLAGS_EN
    input  carry, overflow, negative,
`endif
    input  rd1, rd2, alu_result, zero
  );

  modport slave (
    input  wr, addr1, addr2, addr3, ALUControl,
`ifdef DATAPATH_FLAGS_EN
    output carry, overflow, negative,
`endif
    output rd1, rd2, alu_result, zero
  );
endinterface

// File: rtl/datapath_core.sv
// Execute datapath: 4-entry register file, combinational ALU, ALU result written back on wr.
// Define DATAPATH_FLAGS_EN to add the carry/overflow/negative outputs.
module datapath_core #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  datapath_core_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] result;
  logic             slt;
  alu_op_e          op;

  assign op   = alu_op_e'(bus.ALUControl);
  assign op_a = regs_q[bus.addr1];
  assign op_b = regs_q[bus.addr2];
  assign slt  = $signed(op_a) < $signed(op_b);

`ifdef DATAPATH_FLAGS_EN
  // Extended by one bit so the top bit is the carry-out (ADD) or NOT-borrow (SUB).
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  assign add_ext = {1'b0, op_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_res = add_ext[WIDTH-1:0];
  assign sub_res = sub_ext[WIDTH-1:0];
`else
  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    case (op)
      ALU_ADD:  result = add_res;
      ALU_SUB:  result = sub_res;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_PASS: result = op_b;
      default:  result = '0;
    endcase
  end

  // Write-back: operands are read from regs_q, so addr3 aliasing addr1/addr2 uses pre-edge values.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr) regs_d[bus.addr3] = result;
  end

  always_ff @(posedge clk) begin
    // NOTE: the register file is only four words, each with a defined power-up value, so it is
    // reset like ordinary flops rather than left to a RAM macro.
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      regs_q[0] <= '0;
      regs_q[1] <= WIDTH'(1);
      regs_q[2] <= '1;
      regs_q[3] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.rd1        = op_a;
  assign bus.rd2        = op_b;
  assign bus.alu_result = result;
  assign bus.zero       = (result == '0);

`ifdef DATAPATH_FLAGS_EN
  always_comb begin
    bus.carry    = 1'b0;
    bus.overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        bus.carry    = add_ext[WIDTH];
        bus.overflow = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        bus.carry    = sub_ext[WIDTH];
        bus.overflow = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      default: ;
    endcase
  end
  assign bus.negative = result[WIDTH-1];
`endif

endmodule

// File: tb/tb_datapath_core.sv
// Directed self-checking bench for datapath_core: reset values, write-back, hold, aliasing,
// all eight ALU codes and reset-over-write priority. Flag checks compile in with DATAPATH_FLAGS_EN.
module tb_datapath_core;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  datapath_core_if #(.WIDTH(32)) bus ();

  datapath_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                       input logic [2:0] op, input logic w);
    bus.addr1      = a1;
    bus.addr2      = a2;
    bus.addr3      = a3;
    bus.ALUControl = op;
    bus.wr         = w;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    bus.wr    = 1'b0;
    bus.addr1 = idx;
    bus.addr2 = idx;
    #1;
    check({tag, "_rd1"}, bus.rd1, exp);
    check({tag, "_rd2"}, bus.rd2, exp);
  endtask

  task automatic expect_reset_values(input string tag);
    expect_reg({tag, "_r0"}, 2'd0, 32'h0000_0000);
    expect_reg({tag, "_r1"}, 2'd1, 32'h0000_0001);
    expect_reg({tag, "_r2"}, 2'd2, 32'hFFFF_FFFF);
    expect_reg({tag, "_r3"}, 2'd3, 32'h0000_0000);
  endtask

  // Expected results for every opcode: set A is a=7FFFFFFF,b=1; set B is a=80000000,b=1.
  logic [31:0] exp_set_a [8];
  logic [31:0] exp_set_b [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_set_a = '{32'h8000_0000, 32'h7FFF_FFFE, 32'h0000_0001, 32'h7FFF_FFFF,
                  32'h7FFF_FFFE, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
    exp_set_b = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001,
                  32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE, 32'h0000_0001};

    rst = 1'b1;
    drive(2'd0, 2'd0, 2'd0, OP_ADD, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    expect_reset_values("reset");

    // R1 - R1 -> R1; old value visible until the edge.
    drive(2'd1, 2'd1, 2'd1, OP_SUB, 1'b1);
    check("sub_self_result", bus.alu_result, 32'h0000_0000);
    check("sub_self_zero", 32'(bus.zero), 32'd1);
    check("sub_self_old_rd1", bus.rd1, 32'h0000_0001);
    tick();
    expect_reg("sub_self_r1", 2'd1, 32'h0000_0000);

    // R0 = R2 & R2, then R2 = R1 + R0.
    drive(2'd2, 2'd2, 2'd0, OP_AND, 1'b1);
    check("and_result", bus.alu_result, 32'hFFFF_FFFF);
    check("and_zero", 32'(bus.zero), 32'd0);
    tick();
    expect_reg("and_r0", 2'd0, 32'hFFFF_FFFF);
    drive(2'd1, 2'd0, 2'd2, OP_ADD, 1'b1);
    check("add_result", bus.alu_result, 32'hFFFF_FFFF);
    tick();
    expect_reg("add_r2", 2'd2, 32'hFFFF_FFFF);

    // R3 = R0 - R0, then an OR with wr=0 must not disturb R3.
    drive(2'd0, 2'd0, 2'd3, OP_SUB, 1'b1);
    check("sub_r0_zero", 32'(bus.zero), 32'd1);
    tick();
    expect_reg("sub_r3", 2'd3, 32'h0000_0000);
    drive(2'd0, 2'd1, 2'd3, OP_OR, 1'b0);
    check("hold_or_result", bus.alu_result, 32'hFFFF_FFFF);
    tick();
    expect_reg("hold_r3", 2'd3, 32'h0000_0000);

    // R1 = SLT(R2=-1, R1=0) = 1.
    drive(2'd2, 2'd1, 2'd1, OP_SLT, 1'b1);
    check("slt_true", bus.alu_result, 32'h0000_0001);
    tick();
    expect_reg("slt_r1", 2'd1, 32'h0000_0001);

    // R3 = pass R2 (-1), then double it 31 times to reach 80000000.
    drive(2'd0, 2'd2, 2'd3, OP_PASS, 1'b1);
    tick();
    drive(2'd3, 2'd3, 2'd3, OP_ADD, 1'b1);
    repeat (31) tick();
    expect_reg("double_r3", 2'd3, 32'h8000_0000);

    // R0 = NOR(R3, R3) = 7FFFFFFF.
    drive(2'd3, 2'd3, 2'd0, OP_NOR, 1'b1);
    tick();
    expect_reg("nor_r0", 2'd0, 32'h7FFF_FFFF);

    // Signed overflow on 7FFFFFFF + 1, and SLT(1, -1) = 0.
    drive(2'd0, 2'd1, 2'd0, OP_ADD, 1'b0);
    check("ovf_add_result", bus.alu_result, 32'h8000_0000);
`ifdef DATAPATH_FLAGS_EN
    check("ovf_add_overflow", 32'(bus.overflow), 32'd1);
    check("ovf_add_carry", 32'(bus.carry), 32'd0);
    check("ovf_add_negative", 32'(bus.negative), 32'd1);
    drive(2'd3, 2'd1, 2'd0, OP_SUB, 1'b0);
    check("ovf_sub_result", bus.alu_result, 32'h7FFF_FFFF);
    check("ovf_sub_overflow", 32'(bus.overflow), 32'd1);
    check("ovf_sub_carry", 32'(bus.carry), 32'd1);
    drive(2'd1, 2'd0, 2'd0, OP_SUB, 1'b0);
    check("borrow_sub_carry", 32'(bus.carry), 32'd0);
    check("borrow_sub_overflow", 32'(bus.overflow), 32'd0);
    drive(2'd2, 2'd2, 2'd0, OP_ADD, 1'b0);
    check("carry_add_carry", 32'(bus.carry), 32'd1);
    check("carry_add_overflow", 32'(bus.overflow), 32'd0);
`endif
    drive(2'd1, 2'd2, 2'd0, OP_SLT, 1'b0);
    check("slt_false", bus.alu_result, 32'h0000_0000);
    check("slt_false_zero", 32'(bus.zero), 32'd1);

    // Every opcode on two operand sets.
    for (int op = 0; op < 8; op++) begin
      drive(2'd0, 2'd1, 2'd0, 3'(op), 1'b0);
      check($sformatf("op%0d_set_a", op), bus.alu_result, exp_set_a[op]);
      drive(2'd3, 2'd1, 2'd0, 3'(op), 1'b0);
      check($sformatf("op%0d_set_b", op), bus.alu_result, exp_set_b[op]);
    end

    // Reset wins over a simultaneous write of 80000000 into R0.
    drive(2'd0, 2'd1, 2'd0, OP_ADD, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reset_values("rst_over_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
